// File: rtl/hu_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory-wait freeze and a producer scoreboard for E/M/W.
// Optional HU_NO_FWD_STALL_EN: stall on any RAW hit in E/M/W for pipelines without forwarding.
module hu_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Rs1_D,
    input  logic [4:0]  Rs2_D,
    input  logic        reg_ren_D,
    input  logic        RegWrite_D,
    input  logic        MemRead_D,
    input  logic        valid_D,
    input  logic [4:0]  Rd_D,
    input  logic        branch_taken_E,
    input  logic        mem_req_M,
    input  logic        mem_ready_M,
    output logic        stall_F,
    output logic        stall_D,
    output logic        stall_E,
    output logic        stall_M,
    output logic        flush_D,
    output logic        flush_E,
    output logic [4:0]  Rd_M,
    output logic [4:0]  Rd_W,
    output logic        RegWrite_M,
    output logic        RegWrite_W,
    output logic [15:0] stall_cnt,
    output logic        mem_timeout
);

    typedef enum logic [0:0] {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } sb_t;

    state_t     state_r;
    state_t     state_nxt_s;
    sb_t        sb_e_r;
    sb_t        sb_m_r;
    sb_t        sb_w_r;
    sb_t        d_entry_s;
    logic [7:0] wait_cnt_r;
    logic       freeze_s;
    logic       load_use_s;
    logic       data_haz_s;

    // A scoreboard entry hits when it will write a register the decode stage reads.
    function automatic logic raw_hit(input sb_t e, input logic [4:0] rs1, input logic [4:0] rs2);
        return e.valid && e.rw && ((rs1 == e.rd) || (rs2 == e.rd));
    endfunction

    // Decode entry, hazard detection and freeze condition.
    always_comb begin
        d_entry_s.valid = valid_D;
        d_entry_s.rd    = Rd_D;
        d_entry_s.rw    = valid_D && RegWrite_D && (Rd_D != 5'd0);
        d_entry_s.mr    = valid_D && MemRead_D;

        load_use_s = valid_D && reg_ren_D && sb_e_r.mr && raw_hit(sb_e_r, Rs1_D, Rs2_D);
`ifdef HU_NO_FWD_STALL_EN
        data_haz_s = valid_D && reg_ren_D &&
                     (raw_hit(sb_e_r, Rs1_D, Rs2_D) || raw_hit(sb_m_r, Rs1_D, Rs2_D) ||
                      raw_hit(sb_w_r, Rs1_D, Rs2_D));
`else
        data_haz_s = load_use_s;
`endif

        case (state_r)
            RUN:      freeze_s = mem_req_M && !mem_ready_M;
            MEM_WAIT: freeze_s = !mem_ready_M;
            default:  freeze_s = 1'b0;
        endcase
    end

    // Pipeline controls: freeze > branch flush > data-hazard stall > run; all quiet in reset.
    always_comb begin
        stall_F = 1'b0;
        stall_D = 1'b0;
        stall_E = 1'b0;
        stall_M = 1'b0;
        flush_D = 1'b0;
        flush_E = 1'b0;
        if (rst) begin
            stall_F = 1'b0;
        end else if (freeze_s) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            stall_E = 1'b1;
            stall_M = 1'b1;
        end else if (branch_taken_E) begin
            flush_D = 1'b1;
            flush_E = 1'b1;
        end else if (data_haz_s) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
        end else begin
            stall_F = 1'b0;
        end
    end

    // Next-state logic for the memory-wait FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RUN:      state_nxt_s = freeze_s    ? MEM_WAIT : RUN;
            MEM_WAIT: state_nxt_s = mem_ready_M ? RUN      : MEM_WAIT;
            default:  state_nxt_s = RUN;
        endcase
    end

    // FSM state, wait counter and sticky timeout; timeout latches on the edge the counter reaches 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= RUN;
            wait_cnt_r  <= 8'd0;
            mem_timeout <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == RUN) && (state_nxt_s == MEM_WAIT)) begin
                wait_cnt_r <= 8'd0;
            end else if ((state_r == MEM_WAIT) && (wait_cnt_r != 8'hFF)) begin
                wait_cnt_r <= wait_cnt_r + 8'd1;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            if ((state_r == MEM_WAIT) && (wait_cnt_r == 8'hFE)) begin
                mem_timeout <= 1'b1;
            end else begin
                mem_timeout <= mem_timeout;
            end
        end
    end

    // Scoreboard shift; a bubble enters E whenever E is flushed (load stall or branch).
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_e_r <= '0;
            sb_m_r <= '0;
            sb_w_r <= '0;
        end else if (!freeze_s) begin
            sb_e_r <= flush_E ? sb_t'(8'd0) : d_entry_s;
            sb_m_r <= sb_e_r;
            sb_w_r <= sb_m_r;
        end else begin
            sb_e_r <= sb_e_r;
            sb_m_r <= sb_m_r;
            sb_w_r <= sb_w_r;
        end
    end

    // Saturating count of fetch-stall cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (stall_F && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end else begin
            stall_cnt <= stall_cnt;
        end
    end

    assign Rd_M       = sb_m_r.rd;
    assign RegWrite_M = sb_m_r.rw;
    assign Rd_W       = sb_w_r.rd;
    assign RegWrite_W = sb_w_r.rw;

endmodule

// File: tb/tb_hu_hazard_ctrl.sv
// Directed self-checking bench for hu_hazard_ctrl (default build and HU_NO_FWD_STALL_EN build).
module tb_hu_hazard_ctrl;

`ifdef HU_NO_FWD_STALL_EN
    localparam logic NFS = 1'b1;
`else
    localparam logic NFS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  Rs1_D, Rs2_D, Rd_D;
    logic        reg_ren_D, RegWrite_D, MemRead_D, valid_D;
    logic        branch_taken_E, mem_req_M, mem_ready_M;
    logic        stall_F, stall_D, stall_E, stall_M, flush_D, flush_E;
    logic [4:0]  Rd_M, Rd_W;
    logic        RegWrite_M, RegWrite_W;
    logic [15:0] stall_cnt;
    logic        mem_timeout;

    int passed = 0;
    int fails  = 0;
    int total  = 0;
    int exp_cnt = 0;

    hu_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .reg_ren_D(reg_ren_D), .RegWrite_D(RegWrite_D),
        .MemRead_D(MemRead_D), .valid_D(valid_D), .Rd_D(Rd_D),
        .branch_taken_E(branch_taken_E), .mem_req_M(mem_req_M), .mem_ready_M(mem_ready_M),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .flush_D(flush_D), .flush_E(flush_E),
        .Rd_M(Rd_M), .Rd_W(Rd_W), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .stall_cnt(stall_cnt), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    wire [5:0] ctl = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                         input logic ren, input logic [4:0] rs1, input logic [4:0] rs2);
        valid_D = v; Rd_D = rd; RegWrite_D = rw; MemRead_D = mr;
        reg_ren_D = ren; Rs1_D = rs1; Rs2_D = rs2;
    endtask

    initial begin
        // reset with every hazard source active: controls must stay quiet
        rst = 1'b1; branch_taken_E = 1'b1; mem_req_M = 1'b1; mem_ready_M = 1'b0;
        set_d(1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 5'd4, 5'd4);
        #1;
        chk("rst_ctl", 16'(ctl), 16'd0);
        tick();
        chk("rst_rdm", 16'(Rd_M), 16'd0);
        chk("rst_rwm", 16'(RegWrite_M), 16'd0);
        chk("rst_rdw", 16'(Rd_W), 16'd0);
        chk("rst_cnt", stall_cnt, 16'd0);
        chk("rst_tmo", 16'(mem_timeout), 16'd0);
        rst = 1'b0; branch_taken_E = 1'b0; mem_req_M = 1'b0; mem_ready_M = 1'b1;
        set_d(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        tick();

        // lw x5 then dependent add x6,x5,x1
        set_d(1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd2, 5'd0);
        #1;
        chk("lw5_noload", 16'(ctl), 16'd0);
        tick();
        set_d(1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 5'd5, 5'd1);
        #1;
        chk("lu_ctl", 16'(ctl), 16'b110001);
        tick();
        exp_cnt = 1;
        chk("lu_release", 16'(stall_F), 16'(NFS));
        chk("lu_rdm", 16'(Rd_M), 16'd5);
        chk("lu_rwm", 16'(RegWrite_M), 16'd1);
        chk("lu_cnt1", stall_cnt, 16'(exp_cnt));
        tick();
        exp_cnt = exp_cnt + int'(NFS);
        set_d(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        #1;
        chk("lu_rdw", 16'(Rd_W), 16'd5);
        chk("lu_cnt2", stall_cnt, 16'(exp_cnt));
        tick(); tick(); tick();

        // lw x0 never causes a hazard and is not tracked as a writer
        set_d(1'b1, 5'd0, 1'b1, 1'b1, 1'b1, 5'd2, 5'd0);
        tick();
        set_d(1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0);
        #1;
        chk("lwx0_ctl", 16'(ctl), 16'd0);
        tick();
        set_d(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        chk("lwx0_rdm", 16'(Rd_M), 16'd0);
        chk("lwx0_rwm", 16'(RegWrite_M), 16'd0);

        // memory freeze: E=add10, M=add9, W=add3
        set_d(1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        tick();
        set_d(1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        tick();
        set_d(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        mem_req_M = 1'b1; mem_ready_M = 1'b0;
        for (int i = 0; i < 3; i++) begin
            branch_taken_E = (i == 1);
            #1;
            chk("frz_ctl", 16'(ctl), 16'b111100);
            chk("frz_rdm", 16'(Rd_M), 16'd9);
            chk("frz_rdw", 16'(Rd_W), 16'd3);
            tick();
        end
        branch_taken_E = 1'b0;
        exp_cnt = exp_cnt + 3;
        mem_ready_M = 1'b1;
        #1;
        chk("frz_done_ctl", 16'(ctl), 16'd0);
        chk("frz_cnt", stall_cnt, 16'(exp_cnt));
        tick();
        mem_req_M = 1'b0;
        chk("frz_adv_rdm", 16'(Rd_M), 16'd10);
        chk("frz_adv_rdw", 16'(Rd_W), 16'd9);
        #1;
        chk("frz_run_ctl", 16'(ctl), 16'd0);
        tick();

        // branch coincident with load-use: flush wins
        set_d(1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0);
        tick();
        set_d(1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 5'd5, 5'd1);
        branch_taken_E = 1'b1;
        #1;
        chk("br_ctl", 16'(ctl), 16'b000011);
        tick();
        branch_taken_E = 1'b0;
        set_d(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        chk("br_rdm", 16'(Rd_M), 16'd5);
        chk("br_cnt", stall_cnt, 16'(exp_cnt));
        tick();
        chk("br_bubble", 16'(Rd_M), 16'd0);

        // plain ALU producer in M, consumer Rs2=7
        set_d(1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        tick();
        set_d(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        tick();
        set_d(1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 5'd0, 5'd7);
        #1;
        chk("raw_m_stall", 16'(stall_F), 16'(NFS));
        tick();
        exp_cnt = exp_cnt + int'(NFS);
        set_d(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        #1;
        chk("raw_m_clear", 16'(stall_F), 16'd0);
        chk("raw_m_cnt", stall_cnt, 16'(exp_cnt));

        // long wait: timeout after 255 wait cycles, sticky
        mem_req_M = 1'b1; mem_ready_M = 1'b0;
        for (int i = 0; i < 250; i++) tick();
        chk("tmo_early", 16'(mem_timeout), 16'd0);
        for (int i = 0; i < 10; i++) tick();
        chk("tmo_set", 16'(mem_timeout), 16'd1);
        exp_cnt = exp_cnt + 260;
        mem_ready_M = 1'b1;
        #1;
        chk("tmo_ready_ctl", 16'(ctl), 16'd0);
        tick();
        chk("tmo_sticky", 16'(mem_timeout), 16'd1);
        chk("tmo_cnt", stall_cnt, 16'(exp_cnt));

        // reset in the middle of MEM_WAIT
        mem_ready_M = 1'b0;
        tick(); tick();
        exp_cnt = exp_cnt + 2;
        chk("mw_cnt", stall_cnt, 16'(exp_cnt));
        rst = 1'b1; mem_req_M = 1'b0;
        #1;
        chk("mw_rst_ctl", 16'(ctl), 16'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("mw_run_ctl", 16'(ctl), 16'd0);
        chk("mw_tmo_clr", 16'(mem_timeout), 16'd0);
        chk("mw_cnt_clr", stall_cnt, 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
